// File: rtl/rx_ten_eight.sv
// rtl/rx_ten_eight.sv - 8b/10b UART receiver: line sync, mid-bit sampling, 10b group decode
module rx_ten_eight (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [19:0] baud,
    input  logic        rx_in,
    output logic        rx_valid,
    output logic [7:0]  dout,
    output logic        k_out,
    output logic        code_err,
    output logic        frame_err,
    output logic [9:0]  rx_d,
    output logic        rx_busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t      state, state_nx;
    logic        sync1, rx_s, rx_s_q;
    logic [19:0] bl, bl_in, baud_cnt;
    logic [3:0]  bit_cnt;
    logic [9:0]  sh;
    logic        start_edge, expire;

    logic [5:0]  six;
    logic [3:0]  four;
    logic [4:0]  v5;
    logic [2:0]  v3;
    logic        ok6, ok4, is_k, dec_err;

    assign bl_in      = (baud < 20'd2) ? 20'd2 : baud;
    assign expire     = (baud_cnt == 20'd1);
    assign start_edge = rx_s_q & ~rx_s & en & (state == IDLE);
    assign rx_valid   = (state == DONE);
    assign rx_busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_edge) state_nx = START;
            START:   if (expire) state_nx = rx_s ? IDLE : DATA;
            DATA:    if (expire && bit_cnt == 4'd9) state_nx = STOP;
            STOP:    if (expire) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!en) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_q    <= 1'b1;
            bl        <= 20'd0;
            baud_cnt  <= 20'd0;
            bit_cnt   <= 4'd0;
            sh        <= 10'd0;
            dout      <= 8'h00;
            k_out     <= 1'b0;
            code_err  <= 1'b0;
            frame_err <= 1'b0;
            rx_d      <= 10'h000;
        end else begin
            sync1  <= rx_in;
            rx_s   <= sync1;
            rx_s_q <= rx_s;
            state  <= state_nx;
            case (state)
                IDLE: if (start_edge) begin
                    bl       <= bl_in;
                    baud_cnt <= bl_in >> 1;
                end
                START: if (expire) begin
                    baud_cnt <= bl;
                    bit_cnt  <= 4'd0;
                end else begin
                    baud_cnt <= baud_cnt - 20'd1;
                end
                DATA: if (expire) begin
                    sh[bit_cnt] <= rx_s;
                    bit_cnt     <= bit_cnt + 4'd1;
                    baud_cnt    <= bl;
                end else begin
                    baud_cnt <= baud_cnt - 20'd1;
                end
                // Results land on entry to DONE so they are valid alongside the pulse
                STOP: if (expire) begin
                    if (en) begin
                        rx_d      <= sh;
                        dout      <= dec_err ? 8'h00 : {v3, v5};
                        k_out     <= is_k & ~dec_err;
                        code_err  <= dec_err;
                        frame_err <= ~rx_s;
                    end
                end else begin
                    baud_cnt <= baud_cnt - 20'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        six  = {sh[0], sh[1], sh[2], sh[3], sh[4], sh[5]};
        four = {sh[6], sh[7], sh[8], sh[9]};
        ok6  = 1'b1;
        v5   = 5'd0;
        case (six)
            6'b100111, 6'b011000: v5 = 5'd0;
            6'b011101, 6'b100010: v5 = 5'd1;
            6'b101101, 6'b010010: v5 = 5'd2;
            6'b110001:            v5 = 5'd3;
            6'b110101, 6'b001010: v5 = 5'd4;
            6'b101001:            v5 = 5'd5;
            6'b011001:            v5 = 5'd6;
            6'b111000, 6'b000111: v5 = 5'd7;
            6'b111001, 6'b000110: v5 = 5'd8;
            6'b100101:            v5 = 5'd9;
            6'b010101:            v5 = 5'd10;
            6'b110100:            v5 = 5'd11;
            6'b001101:            v5 = 5'd12;
            6'b101100:            v5 = 5'd13;
            6'b011100:            v5 = 5'd14;
            6'b010111, 6'b101000: v5 = 5'd15;
            6'b011011, 6'b100100: v5 = 5'd16;
            6'b100011:            v5 = 5'd17;
            6'b010011:            v5 = 5'd18;
            6'b110010:            v5 = 5'd19;
            6'b001011:            v5 = 5'd20;
            6'b101010:            v5 = 5'd21;
            6'b011010:            v5 = 5'd22;
            6'b111010, 6'b000101: v5 = 5'd23;
            6'b110011, 6'b001100: v5 = 5'd24;
            6'b100110:            v5 = 5'd25;
            6'b010110:            v5 = 5'd26;
            6'b110110, 6'b001001: v5 = 5'd27;
            6'b001110, 6'b001111, 6'b110000: v5 = 5'd28;
            6'b101110, 6'b010001: v5 = 5'd29;
            6'b011110, 6'b100001: v5 = 5'd30;
            6'b101011, 6'b010100: v5 = 5'd31;
            default:              ok6 = 1'b0;
        endcase
        is_k = (six == 6'b001111) || (six == 6'b110000);
        ok4  = 1'b1;
        v3   = 3'd0;
        // K28 4b codes overlap data codes; the 6b half fixes which disparity column applies
        if (six == 6'b001111) begin
            case (four)
                4'b0100: v3 = 3'd0;
                4'b1001: v3 = 3'd1;
                4'b0101: v3 = 3'd2;
                4'b0011: v3 = 3'd3;
                4'b0010: v3 = 3'd4;
                4'b1010: v3 = 3'd5;
                4'b0110: v3 = 3'd6;
                4'b1000: v3 = 3'd7;
                default: ok4 = 1'b0;
            endcase
        end else if (six == 6'b110000) begin
            case (four)
                4'b1011: v3 = 3'd0;
                4'b0110: v3 = 3'd1;
                4'b1010: v3 = 3'd2;
                4'b1100: v3 = 3'd3;
                4'b1101: v3 = 3'd4;
                4'b0101: v3 = 3'd5;
                4'b1001: v3 = 3'd6;
                4'b0111: v3 = 3'd7;
                default: ok4 = 1'b0;
            endcase
        end else begin
            case (four)
                4'b1011, 4'b0100: v3 = 3'd0;
                4'b1001:          v3 = 3'd1;
                4'b0101:          v3 = 3'd2;
                4'b1100, 4'b0011: v3 = 3'd3;
                4'b1101, 4'b0010: v3 = 3'd4;
                4'b1010:          v3 = 3'd5;
                4'b0110:          v3 = 3'd6;
                4'b1110, 4'b0001, 4'b0111, 4'b1000: v3 = 3'd7;
                default:          ok4 = 1'b0;
            endcase
        end
        dec_err = ~ok6 | ~ok4;
    end

endmodule
